ifetch_queue: RTL

Instruction fetch stage placed directly upstream of `cpu`. Keeps the fetch PC, issues word reads to a fixed-latency instruction memory and buffers returned words with their PCs in a small prefetch queue. Presents them to `cpu` on `cpu_instruction` / `cpu_instruction_RDY_BSY`. Supports a redirect from the execute stage (branch/jump), which flushes everything in flight.

---
 rtl/ifetch_queue_pkg.sv | 23 ++
 rtl/ifetch_queue_if.sv | 26 ++
 rtl/ifetch_queue_fifo.sv | 69 ++++++
 rtl/ifetch_queue.sv | 94 +++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013; // addi x0,x0,0

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_REDIR
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Memory-side and cpu-side handshake of the fetch queue.
interface ifetch_queue_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        cpu_ready;
    logic [31:0] cpu_instruction;
    logic        cpu_instruction_RDY_BSY;
    logic [31:0] cpu_instruction_pc;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr,
        output cpu_instruction, cpu_instruction_RDY_BSY, cpu_instruction_pc,
        input  imem_rdata, cpu_ready
    );

    // Memory and cpu side.
    modport slave (
        input  imem_req, imem_addr,
        input  cpu_instruction, cpu_instruction_RDY_BSY, cpu_instruction_pc,
        output imem_rdata, cpu_ready
    );

endinterface

// File: rtl/ifetch_queue_fifo.sv
// Prefetch FIFO holding {pc, instr} entries; pointers wrap modulo DEPTH.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  entry_t         push_data,
    input  logic           pop,
    input  logic           clear,
    output logic [PTR_W:0] count,
    output logic           not_empty,
    output entry_t         head
);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];

    // Next pointers, count and storage; clear discards everything including a same-cycle push.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Control state: pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is data only and needs no reset; occupancy guards its validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count     = count_q;
    assign not_empty = (count_q != '0);
    assign head      = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: PC generation, credit-limited memory reads and a prefetch queue.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic           cpu_clk,
    input  logic           cpu_rst_n,
    input  logic           fetch_en,
    input  logic           redirect_valid,
    input  logic [31:0]    redirect_pc,
    ifetch_queue_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic               inflight_q, inflight_d;
    logic               req;
    logic               credit;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   occupancy;
    logic               head_valid;
    entry_t             head;
    entry_t             push_entry;
    logic               push, pop;

    // Queued entries plus the one read still on its way must leave room for another word.
    assign occupancy = count + CNT_W'(inflight_q);
    assign credit    = (occupancy < CNT_W'(DEPTH));

    // A redirect kills the response arriving this cycle and wins over a cpu handshake.
    assign push       = inflight_q && !redirect_valid;
    assign pop        = head_valid && bus.cpu_ready && !redirect_valid;
    assign push_entry = '{pc: fetch_pc_q - 32'd4, instr: bus.imem_rdata};

    // Next state, request issue and PC advance; redirect overrides everything else.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inflight_d = 1'b0;
        req        = 1'b0;
        unique case (state_q)
            S_IDLE:  if (fetch_en) state_d = S_FETCH;
            S_FETCH: if (!fetch_en) state_d = S_IDLE;
            S_REDIR: state_d = fetch_en ? S_FETCH : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_q == S_FETCH && fetch_en && !redirect_valid && credit) begin
            req        = 1'b1;
            inflight_d = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (redirect_valid) begin
            state_d    = S_REDIR;
            fetch_pc_d = word_align(redirect_pc);
        end
    end

    // FSM, fetch PC and outstanding-read flag.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
        end
    end

    ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (cpu_clk),
        .rst_n     (cpu_rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (redirect_valid),
        .count     (count),
        .not_empty (head_valid),
        .head      (head)
    );

    // The PC of the word in flight is fetch_pc - 4: no redirect can sit between request and response.
    assign bus.imem_req                = req;
    assign bus.imem_addr               = fetch_pc_q;
    assign bus.cpu_instruction_RDY_BSY = head_valid;
    assign bus.cpu_instruction         = head_valid ? head.instr : '0;
    assign bus.cpu_instruction_pc      = head_valid ? head.pc : '0;

endmodule
